avr_irq_ctrl: RTL and testbench
===============================

Name: avr_irq_ctrl

Overview:
Parametrised interrupt controller. It replaces the fixed 4-input combinational priority encoder that sits in front of the AVR core's iflag/ivect inputs. Per channel it adds an enable mask, a level/edge mode and latched pending bits. Vector acknowledge comes from the core, and a 4-register MMIO window lets firmware configure the block and read its status.

Parameters:
NUM_IRQ, 8, number of interrupt channels (1..8; each config register is one byte)
VECT_W, 3, width of ivect/ack_vect; must satisfy 2**VECT_W >= NUM_IRQ
SYNC_STAGES, 2, synchroniser flops on each irq line (0 = lines already in clk domain)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
irq_lines  in  NUM_IRQ  raw peripheral requests; bit 0 = highest priority
io_re  in  1  MMIO read strobe (block selected)
io_we  in  1  MMIO write strobe (block selected)
io_a  in  2  register offset
io_di  in  8  write data from CPU
io_do  out  8  read data to CPU
ack_stb  in  1  one-cycle pulse: core has taken vector ack_vect
ack_vect  in  VECT_W  acknowledged vector number
iflag  out  1  interrupt request to core
ivect  out  VECT_W  vector of the highest-priority active channel

Behaviour:
- Reset: ENABLE=0, MODE=0 (all level), pending=0, GIE=0, sync flops=0, iflag=0, ivect=0, io_do=0.
- Sync: irq_s = irq_lines delayed by SYNC_STAGES flops. Edge detect compares irq_s with a one-flop-delayed copy, irq_d.
- Level channel (MODE[i]=0):
  - pending[i] = irq_s[i], not latched.
  - Ack and W1C have no effect; the source clears itself.
- Edge channel (MODE[i]=1):
  - Set: irq_s[i] & ~irq_d[i] sets pending[i].
  - Clear: ack_stb with ack_vect==i, or a write of 1 to PENDING bit i.
  - Set and clear in the same cycle: set wins, so no edge is lost.
- Switching MODE from 1 to 0 leaves the latched bit unused. Switching from 0 to 1 clears pending[i] on that write.
- active = pending & ENABLE.
- Outputs, registered (1-cycle latency from pending to pins):
  - iflag <= GIE & |active.
  - ivect <= lowest index i with active[i], else 0.
- Source to iflag latency: SYNC_STAGES+1 cycles (level); SYNC_STAGES+2 cycles (edge).
- After an edge ack, iflag/ivect update on the next clock. If another channel is still active, the next vector appears with no idle cycle.
- Ack for a level or masked channel, or ack_vect >= NUM_IRQ: ignored.
- Register map (bits >= NUM_IRQ read 0, writes ignored):
  - 0 ENABLE: R/W mask.
  - 1 MODE: R/W, 1=edge.
  - 2 PENDING: read returns pending (level bits show live state); write 1 clears edge bits.
  - 3 CTRL: bit7 GIE R/W; bits[VECT_W-1:0] read current ivect; bit6 reads iflag; other bits 0.
- io_do is registered: loaded on the cycle io_re is high, holds otherwise.
- io_re and io_we together: write takes effect; io_do returns the pre-write value.
- A write to ENABLE/GIE affects iflag on the cycle after the write clocks in.
- Reset mid-operation drops all pending state, including edges in flight through the synchroniser.

Decomposition:
- Package avr_irq_pkg:
  - Register offsets IRQ_REG_ENABLE=0, IRQ_REG_MODE=1, IRQ_REG_PENDING=2, IRQ_REG_CTRL=3.
  - CTRL bit positions GIE_BIT=7, IFLAG_BIT=6.
- Sub-module irq_prio_enc: parametrised (NUM_IRQ, VECT_W) combinational lowest-index encoder with any-flag. It replaces the fixed 4-input encoder. Registering is done in avr_irq_ctrl.

Test Plan:
- Reset, then GIE=1, ENABLE=0xFF, MODE=0, irq_lines=0x0C → after SYNC_STAGES+1 cycles iflag=1, ivect=2; drop bit 2 → ivect=3; drop all → iflag=0.
- MODE=0x01, ENABLE=0x01, GIE=1, 1-cycle pulse on irq_lines[0] → iflag=1, ivect=0 held after pulse ends; ack_stb with ack_vect=0 → iflag=0 next cycle; PENDING reads 0x00.
- Edge ch 1 and ch 4 pulsed together, ENABLE=0x12, MODE=0x12 → ivect=1; ack 1 → ivect=4 next cycle with iflag continuously 1; ack 4 → iflag=0.
- New rising edge on edge ch 3 in the same cycle as ack_vect=3 → pending[3] remains 1 and iflag stays 1. Write 0x08 to PENDING → cleared.
- irq_lines=0x20 with ENABLE=0x00 → iflag=0, PENDING reads 0x20. Set ENABLE=0x20 → iflag=1, ivect=5. Clear GIE → iflag=0, CTRL bit6=0.
- Edge ch 0 pending, assert rst for one cycle → all registers 0, iflag=0. Ack with ack_vect=7 when NUM_IRQ=4 → no state change.

Source files
------------

// File: rtl/avr_irq_pkg.sv
// Shared constants for the AVR interrupt controller: MMIO register offsets and
// CTRL register bit positions.
package avr_irq_pkg;

  localparam int unsigned IO_DATA_W = 8;

  localparam logic [1:0] IRQ_REG_ENABLE  = 2'd0;
  localparam logic [1:0] IRQ_REG_MODE    = 2'd1;
  localparam logic [1:0] IRQ_REG_PENDING = 2'd2;
  localparam logic [1:0] IRQ_REG_CTRL    = 2'd3;

  localparam int unsigned GIE_BIT   = 7;
  localparam int unsigned IFLAG_BIT = 6;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index priority encoder with an any-active flag.
// Registering of the results is left to the instantiating block.
module irq_prio_enc #(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned VECT_W  = 3
) (
  input  logic [NUM_IRQ-1:0] active,
  output logic               any_c,
  output logic [VECT_W-1:0]  vect_c
);

  // Scan from the top so the lowest active index is the last one written.
  always_comb begin
    any_c  = |active;
    vect_c = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) vect_c = VECT_W'(i);
    end
  end

endmodule

// File: rtl/avr_irq_ctrl.sv
// Parametrised interrupt controller in front of the AVR core: per-channel
// enable mask, level/edge mode, latched edge pending bits and an MMIO window.
module avr_irq_ctrl
  import avr_irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned VECT_W      = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IRQ-1:0]   irq_lines,
  input  logic                 io_re,
  input  logic                 io_we,
  input  logic [1:0]           io_a,
  input  logic [IO_DATA_W-1:0] io_di,
  output logic [IO_DATA_W-1:0] io_do,
  input  logic                 ack_stb,
  input  logic [VECT_W-1:0]    ack_vect,
  output logic                 iflag,
  output logic [VECT_W-1:0]    ivect
);

  logic [NUM_IRQ-1:0]   irq_s;
  logic [NUM_IRQ-1:0]   irq_d;
  logic [NUM_IRQ-1:0]   enable;
  logic [NUM_IRQ-1:0]   mode;
  logic [NUM_IRQ-1:0]   edge_pend;
  logic                 gie;

  logic [NUM_IRQ-1:0]   wr_data_c;
  logic                 we_enable_c;
  logic                 we_mode_c;
  logic                 we_pend_c;
  logic                 we_ctrl_c;
  logic [NUM_IRQ-1:0]   ack_hit_c;
  logic [NUM_IRQ-1:0]   edge_set_c;
  logic [NUM_IRQ-1:0]   edge_clr_c;
  logic [NUM_IRQ-1:0]   edge_nxt_c;
  logic [NUM_IRQ-1:0]   pending_c;
  logic [NUM_IRQ-1:0]   active_c;
  logic                 any_c;
  logic [VECT_W-1:0]    vect_c;
  logic [IO_DATA_W-1:0] rd_data_c;

  // Input synchroniser; zero stages means the lines are already in clk domain.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign irq_s = irq_lines;
    end else begin : g_sync
      logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= irq_lines;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign irq_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign wr_data_c   = io_di[NUM_IRQ-1:0];
  assign we_enable_c = io_we && (io_a == IRQ_REG_ENABLE);
  assign we_mode_c   = io_we && (io_a == IRQ_REG_MODE);
  assign we_pend_c   = io_we && (io_a == IRQ_REG_PENDING);
  assign we_ctrl_c   = io_we && (io_a == IRQ_REG_CTRL);

  always_comb begin
    ack_hit_c = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_hit_c[i] = ack_stb && (ack_vect == VECT_W'(i));
    end
  end

  // Edge latch: a fresh edge beats a same-cycle ack/W1C; 0->1 mode switch clears.
  always_comb begin
    edge_set_c = mode & irq_s & ~irq_d;
    edge_clr_c = ack_hit_c & mode & enable;
    if (we_pend_c) edge_clr_c = edge_clr_c | wr_data_c;
    edge_nxt_c = (edge_pend & ~edge_clr_c) | edge_set_c;
    if (we_mode_c) edge_nxt_c = edge_nxt_c & ~(wr_data_c & ~mode);
  end

  assign pending_c = (mode & edge_pend) | (~mode & irq_s);
  assign active_c  = pending_c & enable;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .VECT_W  (VECT_W)
  ) u_prio_enc (
    .active  (active_c),
    .any_c   (any_c),
    .vect_c  (vect_c)
  );

  always_comb begin
    rd_data_c = '0;
    case (io_a)
      IRQ_REG_ENABLE:  rd_data_c = IO_DATA_W'(enable);
      IRQ_REG_MODE:    rd_data_c = IO_DATA_W'(mode);
      IRQ_REG_PENDING: rd_data_c = IO_DATA_W'(pending_c);
      default: begin
        rd_data_c[GIE_BIT]     = gie;
        rd_data_c[IFLAG_BIT]   = iflag;
        rd_data_c[VECT_W-1:0]  = ivect;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable    <= '0;
      mode      <= '0;
      edge_pend <= '0;
      gie       <= 1'b0;
      irq_d     <= '0;
      iflag     <= 1'b0;
      ivect     <= '0;
      io_do     <= '0;
    end else begin
      irq_d     <= irq_s;
      edge_pend <= edge_nxt_c;
      if (we_enable_c) enable <= wr_data_c;
      if (we_mode_c)   mode   <= wr_data_c;
      if (we_ctrl_c)   gie    <= io_di[GIE_BIT];
      iflag <= gie & any_c;
      ivect <= vect_c;
      if (io_re) io_do <= rd_data_c;
    end
  end

endmodule

// File: tb/tb_avr_irq_ctrl.sv
// Bench for avr_irq_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the controller.
module tb_avr_irq_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned VW = 3;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  irq_lines = '0;
  logic          io_re = 1'b0;
  logic          io_we = 1'b0;
  logic [1:0]    io_a = '0;
  logic [7:0]    io_di = '0;
  logic [7:0]    io_do;
  logic          ack_stb = 1'b0;
  logic [VW-1:0] ack_vect = '0;
  logic          iflag;
  logic [VW-1:0] ivect;

  logic [3:0]    s_irq = '0;
  logic          s_re = 1'b0;
  logic          s_we = 1'b0;
  logic [1:0]    s_a = '0;
  logic [7:0]    s_di = '0;
  logic [7:0]    s_do;
  logic          s_ack = 1'b0;
  logic [2:0]    s_ackv = '0;
  logic          s_iflag;
  logic [2:0]    s_ivect;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [N-1:0]  m_en = '0, m_mode = '0, m_edge = '0;
  logic          m_gie = 1'b0, m_iflag = 1'b0;
  logic [VW-1:0] m_ivect = '0;
  logic [7:0]    m_do = '0;
  logic [N-1:0]  hist [SS+1];

  always #5 clk = ~clk;

  avr_irq_ctrl #(.NUM_IRQ(N), .VECT_W(VW), .SYNC_STAGES(SS)) u_dut (
    .clk(clk), .rst(rst), .irq_lines(irq_lines), .io_re(io_re), .io_we(io_we),
    .io_a(io_a), .io_di(io_di), .io_do(io_do), .ack_stb(ack_stb),
    .ack_vect(ack_vect), .iflag(iflag), .ivect(ivect)
  );

  avr_irq_ctrl #(.NUM_IRQ(4), .VECT_W(3), .SYNC_STAGES(0)) u_dut4 (
    .clk(clk), .rst(rst), .irq_lines(s_irq), .io_re(s_re), .io_we(s_we),
    .io_a(s_a), .io_di(s_di), .io_do(s_do), .ack_stb(s_ack),
    .ack_vect(s_ackv), .iflag(s_iflag), .ivect(s_ivect)
  );

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [N-1:0] s, d, pend, act;
    logic found;
    if (rst) begin
      m_en = '0; m_mode = '0; m_edge = '0; m_gie = 1'b0;
      m_iflag = 1'b0; m_ivect = '0; m_do = '0;
      for (int j = 0; j <= SS; j++) hist[j] = '0;
    end else begin
      s = hist[SS-1];
      d = hist[SS];
      pend = (m_mode & m_edge) | (~m_mode & s);
      act = pend & m_en;
      if (io_re) begin
        case (io_a)
          2'd0: m_do = m_en;
          2'd1: m_do = m_mode;
          2'd2: m_do = pend;
          default: m_do = {m_gie, m_iflag, 3'b000, m_ivect};
        endcase
      end
      m_iflag = m_gie && (act != '0);
      m_ivect = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (act[i] && !found) begin m_ivect = VW'(i); found = 1'b1; end
      end
      for (int i = 0; i < N; i++) begin
        if (m_mode[i]) begin
          if (s[i] && !d[i]) m_edge[i] = 1'b1;
          else if ((ack_stb && ack_vect == VW'(i) && m_en[i]) ||
                   (io_we && io_a == 2'd2 && io_di[i])) m_edge[i] = 1'b0;
        end
      end
      if (io_we) begin
        case (io_a)
          2'd0: m_en = io_di;
          2'd1: begin m_edge = m_edge & ~(io_di & ~m_mode); m_mode = io_di; end
          2'd3: m_gie = io_di[7];
          default: ;
        endcase
      end
      for (int j = SS; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = irq_lines;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    io_we = 1'b1; io_a = a; io_di = d;
    tick();
    io_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    io_re = 1'b1; io_a = a;
    tick();
    io_re = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    total++; if ({iflag, ivect, io_do} !== 12'h000) begin bad++;
      $display("FAIL reset_out got iflag=%0b ivect=%0d io_do=%02h want 0/0/00", iflag, ivect, io_do); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      total++; if (io_do !== 8'h00) begin bad++;
        $display("FAIL reset_reg%0d got=%02h want=00", a, io_do); end
    end
  endtask

  task automatic test_level();
    wr(2'd3, 8'h80); wr(2'd0, 8'hFF); wr(2'd1, 8'h00);
    irq_lines = 8'h0C;
    repeat (SS) tick();
    total++; if (iflag !== 1'b0) begin bad++;
      $display("FAIL level_early got iflag=%0b want 0", iflag); end
    tick();
    total++; if (iflag !== 1'b1 || ivect !== 3'd2) begin bad++;
      $display("FAIL level_on got iflag=%0b ivect=%0d want 1/2", iflag, ivect); end
    irq_lines = 8'h08;
    repeat (SS + 1) tick();
    total++; if (iflag !== 1'b1 || ivect !== 3'd3) begin bad++;
      $display("FAIL level_next got iflag=%0b ivect=%0d want 1/3", iflag, ivect); end
    irq_lines = 8'h00;
    repeat (SS + 1) tick();
    total++; if (iflag !== 1'b0) begin bad++;
      $display("FAIL level_off got iflag=%0b want 0", iflag); end
  endtask

  task automatic test_edge_ack();
    wr(2'd1, 8'h01); wr(2'd0, 8'h01);
    irq_lines = 8'h01; tick(); irq_lines = 8'h00;
    repeat (SS) tick();
    total++; if (iflag !== 1'b0) begin bad++;
      $display("FAIL edge_early got iflag=%0b want 0", iflag); end
    tick();
    total++; if (iflag !== 1'b1 || ivect !== 3'd0) begin bad++;
      $display("FAIL edge_on got iflag=%0b ivect=%0d want 1/0", iflag, ivect); end
    repeat (3) tick();
    total++; if (iflag !== 1'b1) begin bad++;
      $display("FAIL edge_hold got iflag=%0b want 1", iflag); end
    ack_stb = 1'b1; ack_vect = 3'd0; tick(); ack_stb = 1'b0;
    tick();
    total++; if (iflag !== 1'b0) begin bad++;
      $display("FAIL edge_acked got iflag=%0b want 0", iflag); end
    rd(2'd2);
    total++; if (io_do !== 8'h00) begin bad++;
      $display("FAIL edge_pend_rd got=%02h want=00", io_do); end
  endtask

  task automatic test_back_to_back();
    wr(2'd0, 8'h12); wr(2'd1, 8'h12);
    irq_lines = 8'h12; tick(); irq_lines = 8'h00;
    repeat (SS + 1) tick();
    total++; if (iflag !== 1'b1 || ivect !== 3'd1) begin bad++;
      $display("FAIL b2b_first got iflag=%0b ivect=%0d want 1/1", iflag, ivect); end
    ack_stb = 1'b1; ack_vect = 3'd1; tick(); ack_stb = 1'b0;
    total++; if (iflag !== 1'b1) begin bad++;
      $display("FAIL b2b_gap0 got iflag=%0b want 1", iflag); end
    tick();
    total++; if (iflag !== 1'b1 || ivect !== 3'd4) begin bad++;
      $display("FAIL b2b_second got iflag=%0b ivect=%0d want 1/4", iflag, ivect); end
    ack_stb = 1'b1; ack_vect = 3'd4; tick(); ack_stb = 1'b0;
    tick();
    total++; if (iflag !== 1'b0) begin bad++;
      $display("FAIL b2b_done got iflag=%0b want 0", iflag); end
  endtask

  task automatic test_set_wins();
    wr(2'd0, 8'h08); wr(2'd1, 8'h08);
    irq_lines = 8'h08; tick(); irq_lines = 8'h00;
    repeat (SS + 1) tick();
    total++; if (iflag !== 1'b1 || ivect !== 3'd3) begin bad++;
      $display("FAIL setwin_first got iflag=%0b ivect=%0d want 1/3", iflag, ivect); end
    // Second rising edge reaches the detector on the same clock as the ack.
    irq_lines = 8'h08;
    repeat (SS) tick();
    ack_stb = 1'b1; ack_vect = 3'd3; tick(); ack_stb = 1'b0;
    irq_lines = 8'h00;
    repeat (3) tick();
    total++; if (iflag !== 1'b1 || ivect !== 3'd3) begin bad++;
      $display("FAIL setwin_kept got iflag=%0b ivect=%0d want 1/3", iflag, ivect); end
    rd(2'd2);
    total++; if (io_do !== 8'h08) begin bad++;
      $display("FAIL setwin_pend got=%02h want=08", io_do); end
    wr(2'd2, 8'h08); tick();
    total++; if (iflag !== 1'b0) begin bad++;
      $display("FAIL setwin_w1c got iflag=%0b want 0", iflag); end
  endtask

  task automatic test_mask_gie();
    wr(2'd1, 8'h00); wr(2'd0, 8'h00);
    irq_lines = 8'h20;
    repeat (SS + 2) tick();
    total++; if (iflag !== 1'b0) begin bad++;
      $display("FAIL mask_iflag got=%0b want 0", iflag); end
    rd(2'd2);
    total++; if (io_do !== 8'h20) begin bad++;
      $display("FAIL mask_pend got=%02h want=20", io_do); end
    wr(2'd0, 8'h20); tick();
    total++; if (iflag !== 1'b1 || ivect !== 3'd5) begin bad++;
      $display("FAIL mask_en got iflag=%0b ivect=%0d want 1/5", iflag, ivect); end
    wr(2'd3, 8'h00); tick();
    total++; if (iflag !== 1'b0) begin bad++;
      $display("FAIL gie_off got iflag=%0b want 0", iflag); end
    rd(2'd3);
    total++; if (io_do !== 8'h05) begin bad++;
      $display("FAIL gie_ctrl got=%02h want=05", io_do); end
    irq_lines = 8'h00;
  endtask

  task automatic test_reset_mid();
    wr(2'd3, 8'h80); wr(2'd1, 8'h03); wr(2'd0, 8'h03);
    repeat (SS + 2) tick();
    irq_lines = 8'h01; tick(); irq_lines = 8'h00;
    repeat (SS + 2) tick();
    total++; if (iflag !== 1'b1 || ivect !== 3'd0) begin bad++;
      $display("FAIL rstmid_pre got iflag=%0b ivect=%0d want 1/0", iflag, ivect); end
    irq_lines = 8'h02; tick(); irq_lines = 8'h00;
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if ({iflag, ivect, io_do} !== 12'h000) begin bad++;
      $display("FAIL rstmid_out got iflag=%0b ivect=%0d io_do=%02h want 0/0/00", iflag, ivect, io_do); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      total++; if (io_do !== 8'h00) begin bad++;
        $display("FAIL rstmid_reg%0d got=%02h want=00", a, io_do); end
    end
    repeat (SS + 3) tick();
    total++; if (iflag !== 1'b0) begin bad++;
      $display("FAIL rstmid_late got iflag=%0b want 0", iflag); end
  endtask

  task automatic test_small();
    s_we = 1'b1;
    s_a = 2'd3; s_di = 8'h80; tick();
    s_a = 2'd1; s_di = 8'h01; tick();
    s_a = 2'd0; s_di = 8'hFF; tick();
    s_we = 1'b0;
    s_irq = 4'h1; tick(); s_irq = 4'h0;
    total++; if (s_iflag !== 1'b0) begin bad++;
      $display("FAIL small_early got iflag=%0b want 0", s_iflag); end
    tick();
    total++; if (s_iflag !== 1'b1 || s_ivect !== 3'd0) begin bad++;
      $display("FAIL small_on got iflag=%0b ivect=%0d want 1/0", s_iflag, s_ivect); end
    s_ack = 1'b1; s_ackv = 3'd7; tick(); s_ack = 1'b0;
    tick();
    total++; if (s_iflag !== 1'b1 || s_ivect !== 3'd0) begin bad++;
      $display("FAIL small_ack7 got iflag=%0b ivect=%0d want 1/0", s_iflag, s_ivect); end
    s_re = 1'b1; s_a = 2'd0; tick();
    total++; if (s_do !== 8'h0F) begin bad++;
      $display("FAIL small_enable got=%02h want=0F", s_do); end
    s_a = 2'd2; tick(); s_re = 1'b0;
    total++; if (s_do !== 8'h01) begin bad++;
      $display("FAIL small_pend got=%02h want=01", s_do); end
    s_ack = 1'b1; s_ackv = 3'd0; tick(); s_ack = 1'b0;
    tick();
    total++; if (s_iflag !== 1'b0) begin bad++;
      $display("FAIL small_acked got iflag=%0b want 0", s_iflag); end
  endtask

  task automatic test_random();
    rst = 1'b1; tick(); rst = 1'b0;
    wr(2'd3, 8'h80);
    for (int c = 0; c < 3000; c++) begin
      irq_lines = irq_lines ^ (N'($urandom) & N'($urandom) & N'($urandom));
      io_we = ($urandom_range(0, 9) == 0);
      io_re = ($urandom_range(0, 3) == 0);
      io_a  = 2'($urandom);
      io_di = 8'($urandom);
      if (io_a == 2'd3) io_di[7] = ($urandom_range(0, 3) != 0);
      ack_stb  = ($urandom_range(0, 3) == 0);
      ack_vect = ($urandom_range(0, 2) == 0) ? VW'($urandom) : m_ivect;
      tick();
      total++; if ({iflag, ivect} !== {m_iflag, m_ivect}) begin bad++;
        $display("FAIL rand_out c=%0d got iflag=%0b ivect=%0d want %0b/%0d", c, iflag, ivect, m_iflag, m_ivect); end
      if (io_re) begin
        total++; if (io_do !== m_do) begin bad++;
          $display("FAIL rand_rd c=%0d a=%0d got=%02h want=%02h", c, io_a, io_do, m_do); end
      end
    end
    io_we = 1'b0; io_re = 1'b0; ack_stb = 1'b0; irq_lines = '0;
  endtask

  initial begin
    for (int j = 0; j <= SS; j++) hist[j] = '0;
    #1;
    test_reset();
    test_level();
    test_edge_ack();
    test_back_to_back();
    test_set_wins();
    test_mask_gie();
    test_reset_mid();
    test_small();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
